// File: rtl/qtr_array_reader.sv
// QTR reflectance array reader: charges each enabled sensor, then times the
// decay of every pin in parallel and publishes one frame of TTD results.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | pins Z, waiting for enable & (continuous | start)
// CHARGE | enabled pins driven 1 for CHARGE_CYC cycles
// DECAY  | pins Z, counting up, capturing each channel's first low
// DONE   | one cycle: captures copied to ttd/line/timeout_flag
module qtr_array_reader #(
    parameter int NUM_CH      = 8,
    parameter int CNT_W       = 17,
    parameter int CHARGE_CYC  = 160,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      continuous,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      emit_mode,
    input  logic [CNT_W-1:0]          threshold,
    inout  wire  [NUM_CH-1:0]         ir_snsr,
    output logic [NUM_CH*CNT_W-1:0]   ttd,
    output logic [NUM_CH-1:0]         line,
    output logic [NUM_CH-1:0]         timeout_flag,
    output logic                      frame_valid,
    output logic                      busy,
    output logic                      ir_evenLED,
    output logic                      ir_oddLED
);

    localparam int CHG_W = (CHARGE_CYC > 1) ? $clog2(CHARGE_CYC) : 1;
    localparam logic [CHG_W-1:0] CHG_LOAD  = CHG_W'(CHARGE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    function automatic logic [NUM_CH-1:0] even_mask();
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CH; i++) m[i] = ((i % 2) == 0);
        return m;
    endfunction

    localparam logic [NUM_CH-1:0] EVEN_MASK = even_mask();

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        DECAY  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CHG_W-1:0]  chg_tmr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] act_en;
    logic [NUM_CH-1:0] captured;
    logic [NUM_CH-1:0] cap_to;
    logic [CNT_W-1:0]  cap [NUM_CH];
    logic [NUM_CH-1:0] snsr_s1, snsr_s2;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] drive;
    logic              all_done;
    logic              at_timeout;

    // Two-flop synchroniser; idle-high so an undriven pin never looks decayed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snsr_s1 <= '1;
            snsr_s2 <= '1;
        end else begin
            snsr_s1 <= ir_snsr;
            snsr_s2 <= snsr_s1;
        end
    end

    assign drive = act_en & {NUM_CH{state == CHARGE}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pin
        assign ir_snsr[g] = drive[g] ? 1'b1 : 1'bz;
    end

    // Channels decaying this cycle count as captured so DECAY exits without
    // waiting an extra cycle for the capture flags to settle.
    assign hit        = act_en & ~captured & ~snsr_s2 & {NUM_CH{state == DECAY}};
    assign all_done   = &(captured | hit | ~act_en);
    assign at_timeout = (state == DECAY) && (cnt == TIMEOUT_V);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable && (continuous || start)) state_n = CHARGE;
            CHARGE:  if (chg_tmr == '0) state_n = DECAY;
            DECAY:   if (all_done || at_timeout) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (!enable) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_tmr <= '0;
            act_en  <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && state_n == CHARGE) begin
                chg_tmr <= CHG_LOAD;
                act_en  <= ch_en;
            end else if (state == CHARGE && chg_tmr != '0) begin
                chg_tmr <= chg_tmr - 1'b1;
            end

            if (state == CHARGE) begin
                cnt <= '0;
            end else if (state == DECAY && cnt != TIMEOUT_V) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Per-channel capture; a hit on the timeout cycle still wins over the flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured <= '0;
            cap_to   <= '0;
            for (int i = 0; i < NUM_CH; i++) cap[i] <= '0;
        end else if (state == CHARGE) begin
            captured <= '0;
            cap_to   <= '0;
            for (int i = 0; i < NUM_CH; i++) cap[i] <= '0;
        end else if (state == DECAY) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    cap[i]      <= cnt;
                    captured[i] <= 1'b1;
                end else if (at_timeout && act_en[i] && !captured[i]) begin
                    cap[i]      <= TIMEOUT_V;
                    captured[i] <= 1'b1;
                    cap_to[i]   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ttd          <= '0;
            line         <= '0;
            timeout_flag <= '0;
            frame_valid  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (state == DONE && enable) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    ttd[i*CNT_W +: CNT_W] <= cap[i];
                    line[i]               <= (cap[i] > threshold);
                end
                timeout_flag <= cap_to;
                frame_valid  <= 1'b1;
            end
        end
    end

    // Registered from next-state so the emitters stay cycle-aligned with busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_evenLED <= 1'b0;
            ir_oddLED  <= 1'b0;
        end else begin
            ir_evenLED <= enable && (|(ch_en & EVEN_MASK))
                          && (!emit_mode || state_n != IDLE);
            ir_oddLED  <= enable && (|(ch_en & ~EVEN_MASK))
                          && (!emit_mode || state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_qtr_array_reader.sv
// Self-checking bench for qtr_array_reader: pulled-up sensor pin model plus a
// frame scoreboard filled at stimulus time and drained on frame_valid.
module tb_qtr_array_reader;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 17;
    localparam int CHARGE_CYC  = 4;
    localparam int TIMEOUT_CYC = 100;

    typedef struct packed {
        logic [NUM_CH*CNT_W-1:0] ttd;
        logic [NUM_CH-1:0]       line;
        logic [NUM_CH-1:0]       to;
    } frame_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic                    continuous = 1'b0;
    logic                    start = 1'b0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic                    emit_mode = 1'b0;
    logic [CNT_W-1:0]        threshold = '0;
    wire  [NUM_CH-1:0]       ir_snsr;
    logic [NUM_CH*CNT_W-1:0] ttd;
    logic [NUM_CH-1:0]       line;
    logic [NUM_CH-1:0]       timeout_flag;
    logic                    frame_valid;
    logic                    busy;
    logic                    ir_evenLED;
    logic                    ir_oddLED;

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    frame_t e;
    frame_t last_exp;
    int     fall_t[NUM_CH];
    logic [NUM_CH-1:0] pin_low = '0;

    always #5 clk = ~clk;

    qtr_array_reader #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CHARGE_CYC(CHARGE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .continuous(continuous), .start(start),
        .ch_en(ch_en), .emit_mode(emit_mode), .threshold(threshold), .ir_snsr(ir_snsr),
        .ttd(ttd), .line(line), .timeout_flag(timeout_flag), .frame_valid(frame_valid),
        .busy(busy), .ir_evenLED(ir_evenLED), .ir_oddLED(ir_oddLED)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pin
        pullup pu (ir_snsr[g]);
        assign ir_snsr[g] = pin_low[g] ? 1'b0 : 1'bz;
    end

    // Sensor model: pin i falls fall_t[i] cycles after DECAY entry (-1 = never)
    initial begin : pin_model
        int  cyc_m;
        bit  busy_d;
        cyc_m  = -1;
        busy_d = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!busy) begin
                pin_low = '0;
                cyc_m   = -1;
            end else begin
                cyc_m = busy_d ? cyc_m + 1 : 0;
                for (int i = 0; i < NUM_CH; i++)
                    if (fall_t[i] >= 0 && cyc_m == CHARGE_CYC + fall_t[i]) pin_low[i] = 1'b1;
            end
            busy_d = busy;
        end
    end

    function automatic frame_t model_frame(input logic [NUM_CH-1:0] en, input int thr);
        frame_t f;
        int     t;
        f = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!en[i]) begin
                t = 0;
            end else if (fall_t[i] < 0 || fall_t[i] + 2 > TIMEOUT_CYC) begin
                t = TIMEOUT_CYC;
                f.to[i] = 1'b1;
            end else begin
                t = fall_t[i] + 2;
            end
            f.ttd[i*CNT_W +: CNT_W] = CNT_W'(t);
            f.line[i] = (t > thr);
        end
        return f;
    endfunction

    task automatic set_falls(input int f0, input int f1, input int f2, input int f3);
        fall_t[0] = f0; fall_t[1] = f1; fall_t[2] = f2; fall_t[3] = f3;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_fv(input int budget, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (frame_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        enable = 1'b1; emit_mode = 1'b0; ch_en = 4'hF; rst_n = 1'b0;
        step(3);
        checks++;
        if (ttd !== '0 || line !== '0 || timeout_flag !== '0) begin
            errors++;
            $display("FAIL reset_outputs ttd=%h line=%b to=%b want all zero", ttd, line, timeout_flag);
        end
        checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0 || ir_evenLED !== 1'b0 || ir_oddLED !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b fv=%b even=%b odd=%b want 0000",
                     busy, frame_valid, ir_evenLED, ir_oddLED);
        end
        #2 rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_single();
        int cyc; bit got;
        threshold = 25; ch_en = 4'hF; continuous = 1'b0;
        set_falls(10, 20, 30, 40);
        exp_q.push_back(model_frame(ch_en, 25));
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy got=%b want=1", busy);
        end
        wait_fv(200, cyc, got);
        checks++;
        if (!got || cyc != 48) begin
            errors++; $display("FAIL single_latency got=%0d seen=%0d want=48", cyc, got);
        end
        if (got) begin
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (ttd !== e.ttd) begin errors++; $display("FAIL single_ttd got=%h want=%h", ttd, e.ttd); end
            checks++;
            if (line !== e.line || timeout_flag !== e.to) begin
                errors++; $display("FAIL single_flags line=%b to=%b want %b %b", line, timeout_flag, e.line, e.to);
            end
        end
        wait_fv(40, cyc, got);
        checks++;
        if (got || ttd !== last_exp.ttd) begin
            errors++; $display("FAIL single_hold extra_fv=%0d ttd=%h want=%h", got, ttd, last_exp.ttd);
        end
    endtask

    task automatic test_timeout();
        int cyc; bit got;
        set_falls(10, 20, -1, 40);
        exp_q.push_back(model_frame(ch_en, 25));
        pulse_start();
        wait_fv(300, cyc, got);
        checks++;
        if (!got || cyc != 6 + TIMEOUT_CYC) begin
            errors++; $display("FAIL timeout_latency got=%0d seen=%0d want=%0d", cyc, got, 6 + TIMEOUT_CYC);
        end
        if (got) begin
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (ttd !== e.ttd) begin errors++; $display("FAIL timeout_ttd got=%h want=%h", ttd, e.ttd); end
            checks++;
            if (timeout_flag !== 4'b0100 || line !== e.line) begin
                errors++; $display("FAIL timeout_flags to=%b line=%b want 0100 %b", timeout_flag, line, e.line);
            end
        end
        step(3);
    endtask

    task automatic test_threshold_disabled();
        int cyc; bit got;
        threshold = 22; ch_en = 4'b1011;
        set_falls(10, 20, 5, 40);
        exp_q.push_back(model_frame(ch_en, 22));
        pulse_start();
        ch_en = 4'hF;
        wait_fv(200, cyc, got);
        checks++;
        if (!got || cyc != 48) begin
            errors++; $display("FAIL thresh_latency got=%0d seen=%0d want=48", cyc, got);
        end
        if (got) begin
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (ttd !== e.ttd || timeout_flag !== e.to) begin
                errors++; $display("FAIL thresh_ttd got=%h to=%b want=%h %b", ttd, timeout_flag, e.ttd, e.to);
            end
            checks++;
            if (line !== 4'b1000) begin errors++; $display("FAIL thresh_line got=%b want=1000", line); end
        end
        threshold = 0;
        step(3);
        checks++;
        if (line !== 4'b1000) begin errors++; $display("FAIL thresh_hold got=%b want=1000", line); end
        threshold = 25;
    endtask

    task automatic test_back_to_back();
        int cyc; bit got;
        int want_gap[3];
        want_gap[0] = 48 - 6; want_gap[1] = 69; want_gap[2] = 10;
        ch_en = 4'hF;
        set_falls(10, 20, 30, 40);
        exp_q.push_back(model_frame(ch_en, 25));
        continuous = 1'b1;
        step(6);
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            wait_fv(300, cyc, got);
            checks++;
            if (!got || cyc != want_gap[f]) begin
                errors++; $display("FAIL b2b_gap%0d got=%0d seen=%0d want=%0d", f, cyc, got, want_gap[f]);
            end
            if (!got) break;
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (ttd !== e.ttd || line !== e.line || timeout_flag !== e.to) begin
                errors++; $display("FAIL b2b_frame%0d ttd=%h line=%b to=%b want %h %b %b",
                                   f, ttd, line, timeout_flag, e.ttd, e.line, e.to);
            end
            if (f == 0) set_falls(3, 7, 11, 60);
            if (f == 1) set_falls(1, 1, 1, 1);
            if (f < 2) exp_q.push_back(model_frame(ch_en, 25));
        end
        continuous = 1'b0;
        wait_fv(80, cyc, got);
        checks++;
        if (got || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_stop extra_fv=%0d busy=%b want 0 0", got, busy);
        end
    endtask

    task automatic test_abort_enable();
        int cyc; bit got;
        set_falls(10, 20, 30, 40);
        pulse_start();
        step(CHARGE_CYC + 15);
        enable = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_en_idle busy=%b want=0", busy); end
        wait_fv(120, cyc, got);
        checks++;
        if (got || ttd !== last_exp.ttd || line !== last_exp.line || timeout_flag !== last_exp.to) begin
            errors++; $display("FAIL abort_en_hold fv=%0d ttd=%h line=%b want no fv %h %b",
                               got, ttd, line, last_exp.ttd, last_exp.line);
        end
        enable = 1'b1;
        step(2);
    endtask

    task automatic test_emitters();
        int  bad; bit  saw_busy; bit  got_fv;
        emit_mode = 1'b1; ch_en = 4'b0010;
        set_falls(-1, 10, -1, -1);
        step(2);
        exp_q.push_back(model_frame(ch_en, 25));
        bad = 0; saw_busy = 1'b0; got_fv = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) saw_busy = 1'b1;
            if (ir_oddLED !== busy || ir_evenLED !== 1'b0) bad++;
            if (frame_valid) begin
                got_fv = 1'b1;
                e = exp_q.pop_front();
                checks++;
                if (ttd !== e.ttd || line !== e.line) begin
                    errors++; $display("FAIL emit_frame ttd=%h line=%b want %h %b", ttd, line, e.ttd, e.line);
                end
            end
        end
        checks++;
        if (bad != 0 || !saw_busy || !got_fv) begin
            errors++; $display("FAIL emit_gated bad_cycles=%0d busy_seen=%0d fv=%0d want 0 1 1",
                               bad, saw_busy, got_fv);
        end
        emit_mode = 1'b0;
        step(1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (ir_oddLED !== 1'b1 || ir_evenLED !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL emit_always bad_cycles=%0d want=0", bad); end
    endtask

    task automatic test_abort_reset();
        int cyc; bit got;
        ch_en = 4'hF; emit_mode = 1'b0;
        set_falls(10, 20, 30, 40);
        pulse_start();
        step(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ttd !== '0 || line !== '0 || timeout_flag !== '0 || busy !== 1'b0 ||
            frame_valid !== 1'b0 || ir_oddLED !== 1'b0 || ir_evenLED !== 1'b0) begin
            errors++; $display("FAIL abort_rst ttd=%h line=%b busy=%b odd=%b want all zero",
                               ttd, line, busy, ir_oddLED);
        end
        step(2);
        rst_n = 1'b1;
        step(1);
        exp_q.delete();
        pulse_start();
        wait_fv(200, cyc, got);
        checks++;
        if (!got || cyc != 48 || ttd !== model_frame(ch_en, 25).ttd) begin
            errors++; $display("FAIL post_rst_frame got=%0d seen=%0d ttd=%h want 48", cyc, got, ttd);
        end
    endtask

    initial begin
        set_falls(-1, -1, -1, -1);
        test_reset();
        test_single();
        test_timeout();
        test_threshold_disabled();
        test_back_to_back();
        test_abort_enable();
        test_emitters();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qtr_array_reader.md
QTR_ARRAY_READER -- requirements
Module: qtr_array_reader

Interface
REQ-001 Parameter NUM_CH, default 8: number of reflectance channels, 1..16.
REQ-002 Parameter CNT_W, default 17: width of each time-to-decay (TTD) result.
REQ-003 Parameter CHARGE_CYC, default 160: sensor drive-high cycles (10 us at 16 MHz).
REQ-004 Parameter TIMEOUT_CYC, default 48000: maximum decay count (3 ms at 16 MHz); must be less than 2^CNT_W.
REQ-005 clk  input  1  system clock, 16 MHz (WF_CLK).
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 enable  input  1  block enable; low aborts any frame and holds the FSM in IDLE.
REQ-008 continuous  input  1  1 = frames back-to-back; 0 = one frame per start pulse.
REQ-009 start  input  1  single-cycle frame request, used when continuous=0.
REQ-010 ch_en  input  NUM_CH  per-channel enable, latched at frame start.
REQ-011 emit_mode  input  1  0 = emitters on whenever enabled; 1 = emitters on only while busy.
REQ-012 threshold  input  CNT_W  line-detect threshold.
REQ-013 ir_snsr  inout  NUM_CH  QTR sensor pins: driven 1 when charging, otherwise Z.
REQ-014 ttd  output  NUM_CH*CNT_W  per-channel TTD results; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-015 line  output  NUM_CH  per-channel result ttd > threshold.
REQ-016 timeout_flag  output  NUM_CH  per-channel flag: channel reached TIMEOUT_CYC without decaying.
REQ-017 frame_valid  output  1  one-cycle pulse when ttd, line and timeout_flag update.
REQ-018 busy  output  1  high in CHARGE, DECAY and DONE.
REQ-019 ir_evenLED, ir_oddLED  output  1 each  emitter controls for even and odd channels.

Function
REQ-020 FSM states: IDLE, CHARGE, DECAY, DONE.
REQ-021 IDLE to CHARGE:
  - condition: enable & (continuous | start);
  - ch_en is latched into act_en on this transition;
  - a start pulse while busy is ignored.
REQ-022 CHARGE:
  - ir_snsr[i] is driven 1 for every act_en[i];
  - the state lasts exactly CHARGE_CYC cycles, then goes to DECAY;
  - the decay counter is cleared to 0.
REQ-023 DECAY:
  - all pins are Z;
  - the counter increments by 1 per cycle, starting at 0 on the first DECAY cycle.
REQ-024 Each ir_snsr bit passes through a 2-flop synchroniser with reset value 1; decay detection uses only the synchronised value.
REQ-025 Capture:
  - channel i captures the counter value on the first DECAY cycle its synchronised input is 0;
  - later cycles never overwrite the capture within the frame;
  - disabled channels capture 0 and their timeout_flag is 0.
REQ-026 DECAY exits to DONE when either:
  - all act_en channels have captured; or
  - the counter equals TIMEOUT_CYC.
  At timeout, uncaptured channels take TIMEOUT_CYC and set timeout_flag.
REQ-027 Counter saturates at TIMEOUT_CYC and never wraps.
REQ-028 DONE lasts 1 cycle:
  - ttd, line and timeout_flag are registered from the captures;
  - frame_valid pulses in the following cycle, aligned with the new output values;
  - DONE then goes to IDLE.
REQ-029 Outputs hold their last frame's values between frames.
REQ-030 Continuous mode: IDLE is visited for exactly 1 cycle between frames.
REQ-031 enable deasserted in any state:
  - FSM goes to IDLE on the next edge and pins go Z;
  - no frame_valid is issued;
  - ttd, line and timeout_flag retain their previous values.
REQ-032 line[i] = (ttd[i] > threshold), strictly greater, evaluated at DONE. A later threshold change does not alter line until the next frame.
REQ-033 ir_evenLED is asserted when enable and any even-index ch_en bit is set, further gated by busy when emit_mode=1. ir_oddLED follows the same rule for odd-index bits.

Reset
REQ-034 On rst_n low, immediately:
  - FSM goes to IDLE and ir_snsr goes Z;
  - ttd, line, timeout_flag, frame_valid, busy, act_en and counters are all 0;
  - LEDs are 0;
  - synchroniser flops are 1.
REQ-035 Leaving reset requires no start-up sequence; the first frame begins on the first qualifying cycle after rst_n rises.

Verification
REQ-036 Scenario 1, single frame:
  - stimulus: NUM_CH=4, CHARGE_CYC=4, TIMEOUT_CYC=100, continuous=0, ch_en=4'hF; start pulse; model pins fall 10, 20, 30, 40 cycles after DECAY entry;
  - response: busy within 1 cycle; pins driven for 4 cycles; ttd = 12, 22, 32, 42 (2-cycle synchroniser offset); one frame_valid; timeout_flag=0.
REQ-037 Scenario 2, timeout:
  - stimulus: as scenario 1, but channel 2 never falls;
  - response: ttd[2]=100; timeout_flag=4'b0100; DONE entered when the counter reaches 100.
REQ-038 Scenario 3, threshold and disabled channel:
  - stimulus: threshold=22, ch_en=4'b1011;
  - response: line=4'b1000; ttd[2]=0; early exit once channels 0, 1 and 3 have captured.
REQ-039 Scenario 4, continuous mode:
  - stimulus: continuous=1 for 3 frames;
  - response: 3 frame_valid pulses, each separated by frame length + 1 IDLE cycle; start is ignored while busy.
REQ-040 Scenario 5, aborts:
  - enable dropped mid-DECAY: IDLE next cycle, pins Z, outputs unchanged, no frame_valid;
  - rst_n asserted mid-CHARGE: all outputs 0 asynchronously.
REQ-041 Scenario 6, emitters:
  - stimulus: emit_mode=1, ch_en=4'b0010;
  - response: ir_oddLED equals busy; ir_evenLED=0.
  - stimulus: emit_mode=0;
  - response: ir_oddLED=1 continuously while enabled.
